wb_reg128_master: RTL and testbench

Wishbone B4 pipelined initiator that moves one 128-bit value to or from a 128-bit register as four 32-bit word transactions. It is the bus-side driver for 128-bit control registers such as the `areg` type: word offset 0 carries bits [127:96] and offset 3 carries bits [31:0]. It sits between a local sequencer or test controller and the Wishbone fabric. It holds `wb_cyc_o` for the whole 4-word burst and keeps one transaction outstanding at a time.

---
 rtl/wb_reg128_master.sv | 162 ++++++++++++++++
 tb/tb_wb_reg128_master.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg128_master.sv
// Wishbone B4 pipelined initiator: moves one 128-bit value as four 32-bit word transactions.
// Optional per-word ack timeout enabled by defining WB_REG128_TIMEOUT_EN.
module wb_reg128_master #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [127:0]          wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [127:0]          rdata_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i
);

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STB  = 3'd1,
    S_WAIT = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [1:0]     r_k, w_k_nxt;
  logic           r_we, w_we_nxt;
  logic [127:0]   r_shadow, w_shadow_nxt;
  logic           w_accept, w_live, w_ok, w_fail, w_timeout, w_cyc_nxt;

  // Word 0 is the most significant 32 bits of the register.
  function automatic logic [DW-1:0] word_of(input logic [127:0] v, input logic [1:0] k);
    case (k)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

`ifdef WB_REG128_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] r_to_cnt;

  // Counts cycles spent on the current word; cleared whenever not in STB/WAIT.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                  r_to_cnt <= '0;
    else if (r_state == S_STB || r_state == S_WAIT) r_to_cnt <= r_to_cnt + TO_W'(1);
    else                                           r_to_cnt <= '0;
  end

  assign w_timeout = (r_state == S_STB || r_state == S_WAIT) &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  // Next-state logic; a termination counts only once the strobe is (or was) accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_accept    = 1'b0;
    w_live      = 1'b0;
    w_ok        = 1'b0;
    w_fail      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_accept    = 1'b1;
          w_k_nxt     = 2'd0;
          w_state_nxt = S_STB;
        end
      end
      S_STB, S_WAIT: begin
        w_live = (r_state == S_WAIT) || !wb_stall_i;
        w_fail = (w_live && (wb_err_i || wb_rty_i)) || (w_timeout && !(w_live && wb_ack_i));
        w_ok   = w_live && wb_ack_i && !w_fail;
        if (w_fail) begin
          w_state_nxt = S_DONE;
        end else if (w_ok) begin
          if (r_k == 2'd3) begin
            w_state_nxt = S_DONE;
          end else begin
            w_k_nxt     = r_k + 2'd1;
            w_state_nxt = S_NEXT;
          end
        end else if (r_state == S_STB && !wb_stall_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_NEXT:  w_state_nxt = S_STB;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_we_nxt     = w_accept ? we_i : r_we;
  assign w_shadow_nxt = w_accept ? wdata_i : r_shadow;
  assign w_cyc_nxt    = (w_state_nxt == S_STB) || (w_state_nxt == S_WAIT) ||
                        (w_state_nxt == S_NEXT);

  // State, datapath and registered bus/status outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_k      <= 2'd0;
      r_we     <= 1'b0;
      r_shadow <= '0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= 4'h0;
      wb_dat_o <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_we     <= w_we_nxt;
      r_shadow <= w_shadow_nxt;
      if (w_accept)    err_o <= 1'b0;
      else if (w_fail) err_o <= 1'b1;
      if (w_ok && !r_we) begin
        case (r_k)
          2'd0:    rdata_o[127:96] <= wb_dat_i;
          2'd1:    rdata_o[95:64]  <= wb_dat_i;
          2'd2:    rdata_o[63:32]  <= wb_dat_i;
          default: rdata_o[31:0]   <= wb_dat_i;
        endcase
      end
      busy_o   <= (w_state_nxt != S_IDLE);
      done_o   <= (w_state_nxt == S_DONE);
      wb_cyc_o <= w_cyc_nxt;
      wb_stb_o <= (w_state_nxt == S_STB);
      wb_we_o  <= w_cyc_nxt && w_we_nxt;
      wb_sel_o <= w_cyc_nxt ? 4'hF : 4'h0;
      wb_adr_o <= w_cyc_nxt ? (BASE_ADDR + ADDR_WIDTH'({w_k_nxt, 2'b00})) : '0;
      wb_dat_o <= (w_cyc_nxt && w_we_nxt) ? word_of(w_shadow_nxt, w_k_nxt) : '0;
    end
  end

endmodule

// File: tb/tb_wb_reg128_master.sv
// Bench for wb_reg128_master: scripted Wishbone target plus a burst-level reference model.
// Covers both builds (with and without WB_REG128_TIMEOUT_EN).
module tb_wb_reg128_master;

  localparam logic [31:0] BASE = 32'h0000_0A50;

  logic         clk, rst_n, req_i, we_i;
  logic [127:0] wdata_i, rdata_o;
  logic         busy_o, done_o, err_o;
  logic         wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]  wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]   wb_sel_o;
  logic         wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

  wb_reg128_master #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_i), .we_i(we_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-word target script: stall cycles, wait cycles, termination (0 ack, 1 err, 2 rty, 3 ack+err), read data.
  int          plan_s[4], plan_w[4], plan_t[4];
  logic [31:0] plan_rd[4];
  logic [31:0] cap_adr[8], cap_dat[8];
  logic        cap_we[8];
  logic [3:0]  cap_sel[8];
  int          cap_total  = 0;
  int          stable_err = 0;
  logic [127:0] exp_rdata;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scripted target: reacts to the registered bus outputs just after each rising edge.
  initial begin
    int s_idx, s_phase, s_scnt, s_wcnt;
    bit s_term;
    logic [31:0] s_adr0, s_dat0;
    s_idx = 0; s_phase = 0; s_scnt = 0; s_wcnt = 0;
    s_adr0 = '0; s_dat0 = '0;
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0; wb_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0;
      wb_dat_i = $urandom; s_term = 0;
      if (!wb_cyc_o) begin
        s_idx = 0; s_phase = 0; s_scnt = 0;
        wb_ack_i = ($urandom % 4 == 0);
        wb_err_i = ($urandom % 8 == 0);
        wb_rty_i = ($urandom % 8 == 0);
      end else if (s_phase == 0 && wb_stb_o && s_idx < 4) begin
        if (s_scnt == 0) begin
          s_adr0 = wb_adr_o; s_dat0 = wb_dat_o;
        end else if (wb_adr_o !== s_adr0 || wb_dat_o !== s_dat0) begin
          stable_err++;
        end
        if (s_scnt < plan_s[s_idx]) begin
          wb_stall_i = 1; s_scnt++;
        end else begin
          cap_adr[s_idx] = wb_adr_o; cap_dat[s_idx] = wb_dat_o;
          cap_we[s_idx]  = wb_we_o;  cap_sel[s_idx] = wb_sel_o;
          cap_total++;
          if (plan_w[s_idx] == 0) s_term = 1;
          else begin s_phase = 1; s_wcnt = plan_w[s_idx]; end
        end
      end else if (s_phase == 1) begin
        s_wcnt--;
        if (s_wcnt == 0) s_term = 1;
      end
      if (s_term) begin
        case (plan_t[s_idx])
          0:       wb_ack_i = 1;
          1:       wb_err_i = 1;
          2:       wb_rty_i = 1;
          default: begin wb_ack_i = 1; wb_err_i = 1; end
        endcase
        wb_dat_i = plan_rd[s_idx];
        s_idx++; s_phase = 0; s_scnt = 0;
      end
    end
  end

  task automatic set_plan(input int s, input int w);
    for (int k = 0; k < 4; k++) begin
      plan_s[k] = s; plan_w[k] = w; plan_t[k] = 0; plan_rd[k] = $urandom;
    end
  endtask

  // One burst: model predicts strobes, latency, err and read value from the script.
  task automatic run_txn(input logic we, input logic [127:0] wd, input bit pulse_req);
    int f, nstb, lat, c, base_cap, cyc_low, busy_low, got_stb;
    bit done_seen;
    f = 4;
    for (int k = 3; k >= 0; k--) if (plan_t[k] != 0) f = k;
    nstb = (f < 4) ? f + 1 : 4;
    lat = 0;
    for (int k = 0; k < nstb; k++) begin
      lat += plan_s[k] + plan_w[k] + 2;
      if (!we && plan_t[k] == 0) exp_rdata[127 - 32*k -: 32] = plan_rd[k];
    end
    base_cap = cap_total;
    @(negedge clk);
    req_i = 1; we_i = we; wdata_i = wd;
    @(posedge clk); #1;
    req_i = 0; we_i = $urandom; wdata_i = {$urandom, $urandom, $urandom, $urandom};
    c = 0; done_seen = 0; cyc_low = 0; busy_low = 0;
    while (!done_seen && c < lat + 40) begin
      @(negedge clk); c++;
      if (pulse_req) req_i = (c == 3);
      if (done_o) done_seen = 1;
      else begin
        if (!wb_cyc_o) cyc_low++;
        if (!busy_o) busy_low++;
      end
    end
    req_i = 0;
    check("done_seen", done_seen, 1);
    check("done_lat", c, lat);
    check("err", err_o, (f < 4));
    check("busy_at_done", busy_o, 1);
    check("cyc_hold", cyc_low, 0);
    check("busy_hold", busy_low, 0);
    check("stall_stable", stable_err, 0);
    got_stb = cap_total - base_cap;
    check("strobes", got_stb, nstb);
    for (int k = 0; k < nstb && k < got_stb; k++) begin
      check("adr", cap_adr[k], BASE + 32'(4*k));
      check("we", cap_we[k], we);
      check("sel", cap_sel[k], 4'hF);
      if (we) check("wdat", cap_dat[k], wd[127 - 32*k -: 32]);
    end
    check("rdata", rdata_o, exp_rdata);
    @(negedge clk);
    check("idle_after", {busy_o, wb_cyc_o, done_o, wb_sel_o}, 0);
  endtask

  initial begin
    int cyc_low, c;
    rst_n = 0; req_i = 0; we_i = 0; wdata_i = '0; exp_rdata = '0;
    set_plan(0, 0);
    repeat (3) @(negedge clk);
    check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, 0);
    check("rst_status", {busy_o, done_o, err_o}, 0);
    check("rst_rdata", rdata_o, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Zero-wait write of the reference pattern.
    set_plan(0, 0);
    run_txn(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);

    // Zero-wait read.
    set_plan(0, 0);
    for (int k = 0; k < 4; k++) plan_rd[k] = 32'hA000_0000 + 32'(k);
    run_txn(1'b0, '0, 1'b0);
    check("read_literal", rdata_o, 128'hA0000000_A0000001_A0000002_A0000003);

    // Ack-with-accept target stalling two cycles per word.
    set_plan(2, 0);
    run_txn(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // Error on word 2 of a read, with a request pulse mid-burst.
    set_plan(0, 0);
    plan_t[2] = 1;
    run_txn(1'b0, '0, 1'b1);
    check("err_keep_lo", rdata_o[63:0], 64'hA0000002_A0000003);

    // Reset while waiting on word 1.
    set_plan(0, 0);
    plan_w[1] = 1000000;
    @(negedge clk);
    req_i = 1; we_i = 0;
    @(posedge clk); #1;
    req_i = 0;
    repeat (4) @(negedge clk);
    check("in_wait", {wb_cyc_o, wb_stb_o}, 2'b10);
    rst_n = 0;
    #1;
    check("async_rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, 0);
    check("async_rst_status", {busy_o, done_o, err_o}, 0);
    check("async_rst_rdata", rdata_o, 0);
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    set_plan(0, 0);
    run_txn(1'b0, '0, 1'b0);

    // Randomized bursts.
    for (int i = 0; i < 30; i++) begin
      int r;
      for (int k = 0; k < 4; k++) begin
        plan_s[k] = $urandom_range(0, 1);
        plan_w[k] = $urandom_range(0, 2);
        r = $urandom % 12;
        plan_t[k] = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
        plan_rd[k] = $urandom;
      end
      run_txn(1'(($urandom % 2)), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end

    // Target that never acknowledges.
    set_plan(0, 1000000);
    @(negedge clk);
    req_i = 1; we_i = 1;
    @(posedge clk); #1;
    req_i = 0;
`ifdef WB_REG128_TIMEOUT_EN
    c = 0;
    while (c < 20 && !done_o) begin
      @(negedge clk); c++;
    end
    check("to_lat", c, 5);
    check("to_err", err_o, 1);
`else
    cyc_low = 0;
    c = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!wb_cyc_o) cyc_low++;
    end
    check("no_timeout_cyc", cyc_low, c);
    check("no_timeout_busy", {busy_o, done_o}, 2'b10);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
